// File: rtl/max7219_chain_rx_pkg.sv
// Shared definitions for the MAX7219 chain receiver.
//   HDR                : header nibble a transmitter puts in bits [15:12] (ignored on receive)
//   REG_*              : register addresses decoded from bits [11:8] of a 16-bit word
//   max7219_word_t     : one 16-bit serial word split into {hdr, addr, data}
package max7219_types;

  localparam logic [3:0] HDR            = 4'h0;

  localparam logic [3:0] REG_NOOP       = 4'h0;
  localparam logic [3:0] REG_ROW_0      = 4'h1;
  localparam logic [3:0] REG_ROW_1      = 4'h2;
  localparam logic [3:0] REG_ROW_2      = 4'h3;
  localparam logic [3:0] REG_ROW_3      = 4'h4;
  localparam logic [3:0] REG_ROW_4      = 4'h5;
  localparam logic [3:0] REG_ROW_5      = 4'h6;
  localparam logic [3:0] REG_ROW_6      = 4'h7;
  localparam logic [3:0] REG_ROW_7      = 4'h8;
  localparam logic [3:0] REG_DECODE     = 4'h9;
  localparam logic [3:0] REG_INTENSITY  = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

  typedef struct packed {
    logic [3:0] hdr;
    logic [3:0] addr;
    logic [7:0] data;
  } max7219_word_t;

endpackage

// File: rtl/max7219_sync_edge.sv
// Two-flop synchroniser followed by a history flop for one asynchronous input.
//   clk_i   : system clock
//   srst_i  : synchronous active-high reset, all three flops load RESET_VAL
//   async_i : asynchronous input pin
//   level_o : synchronised level (second stage)
//   rise_o  : one-cycle pulse, second stage high and history low
//   fall_o  : one-cycle pulse, second stage low and history high
module max7219_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/max7219_chain_rx.sv
// Behavioural receiver for a daisy chain of DISP_ROWS*DISP_COLUMNS MAX7219 devices.
// Oversamples the serial CLK/DIN/CS lines, shifts the N*16-bit chain register and,
// when CS rises after exactly N*16 bits, commits one word into every device's
// register file on the same clock edge.
//   i_Clk, i_Rst        : system clock, synchronous active-high reset
//   i_MAX7219_CLK/DIN/CS: serial link inputs (asynchronous)
//   o_MAX7219_DOUT      : registered MSB of the chain shift register
//   o_Digits            : digit registers 0..7 per device
//   o_Intensity, o_Scan_Limit, o_Decode_Mode, o_Shutdown_n, o_Display_Test : control regs
//   o_Load_Strobe       : one-cycle pulse on a committed frame
//   o_Frame_Err         : one-cycle pulse when CS rises with the wrong bit count
module max7219_chain_rx
  import max7219_types::*;
#(
  parameter int DISP_ROWS    = 1,
  parameter int DISP_COLUMNS = 1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_MAX7219_CLK,
  input  logic i_MAX7219_DIN,
  input  logic i_MAX7219_CS,
  output logic o_MAX7219_DOUT,
  output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0][7:0] o_Digits,
  output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][3:0]      o_Intensity,
  output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][2:0]      o_Scan_Limit,
  output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0]      o_Decode_Mode,
  output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0]           o_Shutdown_n,
  output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0]           o_Display_Test,
  output logic o_Load_Strobe,
  output logic o_Frame_Err
);

  localparam int N     = DISP_ROWS * DISP_COLUMNS;
  localparam int NBITS = N * 16;
  localparam int CNT_W = $clog2(NBITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NBITS + 1);

  // ---------------------------------------------------------------- input sync
  logic sclk_level, sclk_rise, sclk_fall;
  logic din_level, din_rise, din_fall;
  logic cs_level, cs_rise, cs_fall;

  max7219_sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk_i(i_Clk), .srst_i(i_Rst), .async_i(i_MAX7219_CLK),
    .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  max7219_sync_edge #(.RESET_VAL(1'b0)) u_sync_din (
    .clk_i(i_Clk), .srst_i(i_Rst), .async_i(i_MAX7219_DIN),
    .level_o(din_level), .rise_o(din_rise), .fall_o(din_fall)
  );

  // CS idles high, so it resets high: a reset while CS is low then shows a
  // clean fall afterwards and the next transfer starts from bit 0.
  max7219_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(i_Clk), .srst_i(i_Rst), .async_i(i_MAX7219_CS),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  logic [4:0] unused_edges;
  assign unused_edges = {sclk_level, sclk_fall, din_rise, din_fall, 1'b0};

  // ------------------------------------------------- shift register / counter
  logic [NBITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_en;
  logic             commit;
  logic             frame_err;
  logic             strobe_q, err_q, dout_q;

  // A CLK rise seen in the same cycle as the CS rise is dropped because the
  // synchronised CS level is already high.
  assign shift_en  = sclk_rise & ~cs_level;
  assign commit    = cs_rise & (cnt_q == CNT_FULL);
  assign frame_err = cs_rise & (cnt_q != CNT_FULL);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (shift_en) begin
      sr_d = {sr_q[NBITS-2:0], din_level};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // The shift register keeps its contents across frames; only the count restarts.
    if (cs_fall) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      strobe_q <= commit;
      err_q    <= frame_err;
      dout_q   <= sr_d[NBITS-1];
    end
  end

  assign o_Load_Strobe  = strobe_q;
  assign o_Frame_Err    = err_q;
  assign o_MAX7219_DOUT = dout_q;

  // ---------------------------------------------------- per-device registers
  // Device 0 sits nearest DIN, so it owns the lowest (most recently shifted) word.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dev
      localparam int ROW = gi / DISP_COLUMNS;
      localparam int COL = gi % DISP_COLUMNS;

      max7219_word_t   word;
      logic [3:0]      unused_hdr;
      logic [7:0][7:0] digits_q, digits_d;
      logic [7:0]      decode_q, decode_d;
      logic [3:0]      intensity_q, intensity_d;
      logic [2:0]      scan_q, scan_d;
      logic            shutdown_n_q, shutdown_n_d;
      logic            test_q, test_d;

      assign word       = max7219_word_t'(sr_q[16*gi +: 16]);
      assign unused_hdr = word.hdr;

      always_comb begin
        digits_d     = digits_q;
        decode_d     = decode_q;
        intensity_d  = intensity_q;
        scan_d       = scan_q;
        shutdown_n_d = shutdown_n_q;
        test_d       = test_q;
        if (commit) begin
          case (word.addr)
            REG_ROW_0, REG_ROW_1, REG_ROW_2, REG_ROW_3,
            REG_ROW_4, REG_ROW_5, REG_ROW_6, REG_ROW_7:
              digits_d[3'(word.addr - REG_ROW_0)] = word.data;
            REG_DECODE:       decode_d     = word.data;
            REG_INTENSITY:    intensity_d  = word.data[3:0];
            REG_SCAN_LIMIT:   scan_d       = word.data[2:0];
            REG_SHUTDOWN:     shutdown_n_d = word.data[0];
            REG_DISPLAY_TEST: test_d       = word.data[0];
            default: ;  // no-op and the unused 0xD/0xE addresses
          endcase
        end
      end

      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          digits_q     <= '0;
          decode_q     <= '0;
          intensity_q  <= '0;
          scan_q       <= '0;
          shutdown_n_q <= 1'b0;
          test_q       <= 1'b0;
        end else begin
          digits_q     <= digits_d;
          decode_q     <= decode_d;
          intensity_q  <= intensity_d;
          scan_q       <= scan_d;
          shutdown_n_q <= shutdown_n_d;
          test_q       <= test_d;
        end
      end

      assign o_Digits[ROW][COL]       = digits_q;
      assign o_Decode_Mode[ROW][COL]  = decode_q;
      assign o_Intensity[ROW][COL]    = intensity_q;
      assign o_Scan_Limit[ROW][COL]   = scan_q;
      assign o_Shutdown_n[ROW][COL]   = shutdown_n_q;
      assign o_Display_Test[ROW][COL] = test_q;
    end
  endgenerate

endmodule

// File: tb/tb_max7219_chain_rx.sv
// Bench for max7219_chain_rx: a 1x1 and a 2x2 chain share the serial CLK/DIN
// lines and have separate CS lines. A register-level model of each chain is
// updated from the words of every correctly sized frame.
module tb_max7219_chain_rx;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic sclk = 1'b0;
  logic din = 1'b0;
  logic cs1 = 1'b1;
  logic cs4 = 1'b1;

  logic                    dout1, strobe1, err1;
  logic [0:0][0:0][7:0][7:0] dig1;
  logic [0:0][0:0][3:0]    int1;
  logic [0:0][0:0][2:0]    scan1;
  logic [0:0][0:0][7:0]    dec1;
  logic [0:0][0:0]         shdn1, test1;

  logic                    dout4, strobe4, err4;
  logic [1:0][1:0][7:0][7:0] dig4;
  logic [1:0][1:0][3:0]    int4;
  logic [1:0][1:0][2:0]    scan4;
  logic [1:0][1:0][7:0]    dec4;
  logic [1:0][1:0]         shdn4, test4;

  max7219_chain_rx #(.DISP_ROWS(1), .DISP_COLUMNS(1)) dut1 (
    .i_Clk(clk), .i_Rst(srst), .i_MAX7219_CLK(sclk), .i_MAX7219_DIN(din),
    .i_MAX7219_CS(cs1), .o_MAX7219_DOUT(dout1), .o_Digits(dig1),
    .o_Intensity(int1), .o_Scan_Limit(scan1), .o_Decode_Mode(dec1),
    .o_Shutdown_n(shdn1), .o_Display_Test(test1),
    .o_Load_Strobe(strobe1), .o_Frame_Err(err1)
  );

  max7219_chain_rx #(.DISP_ROWS(2), .DISP_COLUMNS(2)) dut4 (
    .i_Clk(clk), .i_Rst(srst), .i_MAX7219_CLK(sclk), .i_MAX7219_DIN(din),
    .i_MAX7219_CS(cs4), .o_MAX7219_DOUT(dout4), .o_Digits(dig4),
    .o_Intensity(int4), .o_Scan_Limit(scan4), .o_Decode_Mode(dec4),
    .o_Shutdown_n(shdn4), .o_Display_Test(test4),
    .o_Load_Strobe(strobe4), .o_Frame_Err(err4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ----------------------------------------------------------- model state
  logic [7:0][7:0] m_dig  [2][4];
  logic [7:0]      m_dec  [2][4];
  logic [3:0]      m_int  [2][4];
  logic [2:0]      m_scan [2][4];
  logic            m_shdn [2][4];
  logic            m_test [2][4];
  bit              h1[$];   // last 16 bits clocked into the 1x1 chain
  bit              h4[$];   // last 64 bits clocked into the 2x2 chain
  int strobe_cnt1 = 0, strobe_cnt4 = 0, err_cnt1 = 0, err_cnt4 = 0;
  int exp_strobe1 = 0, exp_strobe4 = 0, exp_err1 = 0, exp_err4 = 0;

  always @(negedge clk) begin
    if (strobe1) strobe_cnt1++;
    if (strobe4) strobe_cnt4++;
    if (err1) err_cnt1++;
    if (err4) err_cnt4++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 4; d++) begin
        m_dig[s][d] = '0; m_dec[s][d] = '0; m_int[s][d] = '0;
        m_scan[s][d] = '0; m_shdn[s][d] = 1'b0; m_test[s][d] = 1'b0;
      end
    end
    h1.delete(); h4.delete();
    repeat (16) h1.push_back(1'b0);
    repeat (64) h4.push_back(1'b0);
  endtask

  task automatic model_push(input int s, input bit b);
    if (s == 0) begin h1.push_back(b); void'(h1.pop_front()); end
    else        begin h4.push_back(b); void'(h4.pop_front()); end
  endtask

  // Register-file rules of one device receiving a committed word.
  task automatic model_apply(input int s, input int d, input logic [15:0] w);
    int         a;
    logic [7:0] v;
    a = int'(w[11:8]);
    v = w[7:0];
    if (a >= 1 && a <= 8) m_dig[s][d][a-1] = v;
    else if (a == 9)  m_dec[s][d]  = v;
    else if (a == 10) m_int[s][d]  = v[3:0];
    else if (a == 11) m_scan[s][d] = v[2:0];
    else if (a == 12) m_shdn[s][d] = v[0];
    else if (a == 15) m_test[s][d] = v[0];
  endtask

  task automatic check_regs(input int s, input string tag);
    int n;
    n = (s == 1) ? 4 : 1;
    for (int d = 0; d < n; d++) begin
      logic [63:0] od;
      logic [7:0]  odec;
      logic [3:0]  oi;
      logic [2:0]  os;
      logic        osh, ot;
      if (s == 0) begin
        od = dig1[0][0]; odec = dec1[0][0]; oi = int1[0][0];
        os = scan1[0][0]; osh = shdn1[0][0]; ot = test1[0][0];
      end else begin
        od = dig4[d/2][d%2]; odec = dec4[d/2][d%2]; oi = int4[d/2][d%2];
        os = scan4[d/2][d%2]; osh = shdn4[d/2][d%2]; ot = test4[d/2][d%2];
      end
      check($sformatf("%s c%0d d%0d digits", tag, s, d), od, m_dig[s][d]);
      check($sformatf("%s c%0d d%0d decode", tag, s, d), 64'(odec), 64'(m_dec[s][d]));
      check($sformatf("%s c%0d d%0d intensity", tag, s, d), 64'(oi), 64'(m_int[s][d]));
      check($sformatf("%s c%0d d%0d scan", tag, s, d), 64'(os), 64'(m_scan[s][d]));
      check($sformatf("%s c%0d d%0d shutdown_n", tag, s, d), 64'(osh), 64'(m_shdn[s][d]));
      check($sformatf("%s c%0d d%0d test", tag, s, d), 64'(ot), 64'(m_test[s][d]));
    end
  endtask

  task automatic check_dout(input string tag);
    check({tag, " dout1"}, 64'(dout1), 64'(h1[0]));
    check({tag, " dout4"}, 64'(dout4), 64'(h4[0]));
  endtask

  // One CS-low transfer of nbits bits (MSB first) to chain s, with SCLK at clk/8.
  // Strobe/error and registers are checked one edge before and on the 3rd edge
  // after the CS rise.
  task automatic send_frame(input int s, input logic [79:0] bits, input int nbits);
    int nb;
    bit ok;
    nb = (s == 1) ? 64 : 16;
    ok = (nbits == nb);
    $display("[TB] frame chain=%0d bits=%0d data=%h expect=%s", s, nbits, bits,
             ok ? "commit" : "error");
    @(negedge clk);
    if (s == 1) cs4 = 1'b0; else cs1 = 1'b0;
    wait_cyc(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      din = bits[i];
      wait_cyc(4);
      sclk = 1'b1;
      model_push(s, bits[i]);
      wait_cyc(4);
      sclk = 1'b0;
    end
    wait_cyc(4);
    if (s == 1) cs4 = 1'b1; else cs1 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("strobe early", 64'(s == 1 ? strobe4 : strobe1), 64'(0));
    check("err early", 64'(s == 1 ? err4 : err1), 64'(0));
    check_regs(s, "pre");
    if (ok) begin
      for (int d = 0; d < nb / 16; d++) model_apply(s, d, bits[16*d +: 16]);
      if (s == 1) exp_strobe4++; else exp_strobe1++;
    end else begin
      if (s == 1) exp_err4++; else exp_err1++;
    end
    @(posedge clk); #1;
    check("strobe 3rd edge", 64'(s == 1 ? strobe4 : strobe1), 64'(ok));
    check("err 3rd edge", 64'(s == 1 ? err4 : err1), 64'(!ok));
    check_regs(s, "post");
    @(posedge clk); #1;
    check("strobe width", 64'(s == 1 ? strobe4 : strobe1), 64'(0));
    check("err width", 64'(s == 1 ? err4 : err1), 64'(0));
    check_dout("frame");
  endtask

  // SCLK activity with both CS lines high must not shift anything.
  task automatic idle_clocks(input int k);
    for (int i = 0; i < k; i++) begin
      din = 1'($urandom());
      wait_cyc(4);
      sclk = 1'b1;
      wait_cyc(4);
      sclk = 1'b0;
    end
    wait_cyc(4);
  endtask

  initial begin
    logic [95:0] rv;
    model_reset();
    wait_cyc(4);
    check_regs(0, "reset");
    check_regs(1, "reset");
    check_dout("reset");
    check("reset strobe", 64'({strobe1, strobe4, err1, err4}), 64'(0));
    srst = 1'b0;
    wait_cyc(4);

    // single word into a single device
    send_frame(0, 80'h0355, 16);
    // four words through the 2x2 chain; the last word lands in device 0
    send_frame(1, {16'h0, 16'h0101, 16'h0202, 16'h0304, 16'h0408}, 64);
    // one bit short, one bit long
    send_frame(0, 80'h5A3C & 80'h7FFF, 15);
    send_frame(0, 80'h1_0C01, 17);

    // reset in the middle of a transfer, then a clean frame
    @(negedge clk);
    cs1 = 1'b0;
    wait_cyc(4);
    for (int i = 15; i >= 8; i--) begin
      din = 1'(16'hA5C3 >> i);
      wait_cyc(4); sclk = 1'b1; wait_cyc(4); sclk = 1'b0;
    end
    srst = 1'b1;
    wait_cyc(2);
    cs1 = 1'b1;
    wait_cyc(3);
    srst = 1'b0;
    model_reset();
    wait_cyc(4);
    $display("[TB] reset mid-transfer released");
    check_regs(0, "midrst");
    check_regs(1, "midrst");
    check_dout("midrst");
    send_frame(0, 80'h0C01, 16);

    // control registers and a no-op
    send_frame(0, 80'h0A0F, 16);
    send_frame(0, 80'h0B07, 16);
    send_frame(0, 80'h0F01, 16);
    send_frame(0, 80'h0000, 16);

    // SCLK toggling with CS high between two frames
    idle_clocks(5);
    check_dout("idle1");
    send_frame(0, 80'h85AA, 16);
    idle_clocks(7);
    check_dout("idle2");

    // randomized frames with mostly correct and some wrong lengths
    for (int it = 0; it < 40; it++) begin
      int s, nb, r, nbits;
      s  = int'($urandom_range(0, 1));
      nb = (s == 1) ? 64 : 16;
      r  = int'($urandom_range(0, 9));
      if (r < 7)       nbits = nb;
      else if (r == 7) nbits = nb - 1;
      else if (r == 8) nbits = nb + int'($urandom_range(1, 3));
      else             nbits = int'($urandom_range(0, nb - 2));
      rv = {$urandom(), $urandom(), $urandom()};
      send_frame(s, rv[79:0], nbits);
      if (it % 8 == 3) idle_clocks(2);
    end

    wait_cyc(4);
    check("strobe count 1x1", 64'(strobe_cnt1), 64'(exp_strobe1));
    check("strobe count 2x2", 64'(strobe_cnt4), 64'(exp_strobe4));
    check("err count 1x1", 64'(err_cnt1), 64'(exp_err1));
    check("err count 2x2", 64'(err_cnt4), 64'(exp_err4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
